eq_gain_loader: RTL and testbench

Upstream control stage for the 8-band equalizer. It produces the per-band gain vector `g[7:0]` that the equalizer's gain stages consume. Host writes go into shadow registers. A commit arms the update, and the update is applied only on audio sample boundaries. Each band ramps toward its new target in fixed steps, which prevents zipper noise.

---
 rtl/eq_gain_loader_if.sv | 16 +
 rtl/eq_gain_loader.sv | 86 ++++++++
 tb/tb_eq_gain_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/eq_gain_loader_if.sv
// Host-side write/commit bus for the equalizer gain loader.
interface eq_gain_loader_if #(
  parameter int unsigned BW = 3,
  parameter int unsigned GW = 16
);
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_band;
  logic [GW-1:0] wr_gain;
  logic          commit;

  modport master (output wr_valid, output wr_band, output wr_gain, output commit,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_band, input  wr_gain, input  commit,
                  output wr_ready);
endinterface

// File: rtl/eq_gain_loader.sv
// Shadowed per-band gain loader: commit arms an update that is applied on
// sample ticks, ramping each band toward its target by at most STEP per sample.
module eq_gain_loader #(
  parameter int unsigned    NBANDS  = 8,
  parameter int unsigned    GW      = 16,
  parameter logic [GW-1:0]  STEP    = 'h0100,
  parameter int unsigned    RAMP_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  eq_gain_loader_if.slave   wr,
  input  logic              sample_tick,
  output logic [GW-1:0]     g [NBANDS-1:0],
  output logic              pending,
  output logic              busy
);
  localparam logic [GW-1:0] UNITY = {2'b01, {(GW-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, RAMP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] shadow   [NBANDS-1:0];
  logic [GW-1:0] shadow_d [NBANDS-1:0];
  logic [GW-1:0] target   [NBANDS-1:0];
  logic [GW-1:0] step_g   [NBANDS-1:0];
  logic [GW:0]   diff     [NBANDS-1:0];
  logic [GW:0]   mag      [NBANDS-1:0];
  logic          accept;
  logic          done;

  assign wr.wr_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign pending     = (state_q == LOAD);
  assign busy        = (state_q == ARMED) || (state_q == RAMP);

  // Shadow view including this cycle's write, so a write coincident with
  // commit lands in the target as well.
  always_comb begin
    for (int unsigned k = 0; k < NBANDS; k++) shadow_d[k] = shadow[k];
    if (accept) shadow_d[wr.wr_band] = wr.wr_gain;
  end

  // 17-bit difference keeps full-scale ramps free of wrap-around.
  always_comb begin
    done = 1'b1;
    for (int unsigned k = 0; k < NBANDS; k++) begin
      diff[k] = {1'b0, target[k]} - {1'b0, g[k]};
      mag[k]  = diff[k][GW] ? (~diff[k] + 1'b1) : diff[k];
      if (RAMP_EN == 0 || mag[k] <= {1'b0, STEP})
        step_g[k] = target[k];
      else if (diff[k][GW])
        step_g[k] = g[k] - STEP;
      else
        step_g[k] = g[k] + STEP;
      if (step_g[k] != target[k]) done = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = LOAD;
      LOAD:        if (wr.commit) state_d = ARMED;
      ARMED, RAMP: if (sample_tick) state_d = done ? IDLE : RAMP;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NBANDS; k++) begin
        g[k]      <= UNITY;
        shadow[k] <= UNITY;
        target[k] <= UNITY;
      end
    end else begin
      state_q <= state_d;
      for (int unsigned k = 0; k < NBANDS; k++) begin
        shadow[k] <= shadow_d[k];
        if (state_q == LOAD && wr.commit) target[k] <= shadow_d[k];
        if (busy && sample_tick)          g[k]      <= step_g[k];
      end
    end
  end
endmodule

// File: tb/tb_eq_gain_loader.sv
// Directed bench for eq_gain_loader with hand-computed expected gains.
module tb_eq_gain_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [15:0] g  [7:0];
  logic [15:0] g0 [7:0];
  logic        pending, busy, pending0, busy0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  eq_gain_loader_if #(.BW(3), .GW(16)) bus ();
  eq_gain_loader_if #(.BW(3), .GW(16)) bus0 ();

  eq_gain_loader #(.NBANDS(8), .GW(16), .STEP(16'h0100), .RAMP_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr(bus), .sample_tick(sample_tick),
    .g(g), .pending(pending), .busy(busy));

  eq_gain_loader #(.NBANDS(8), .GW(16), .STEP(16'h0100), .RAMP_EN(0)) dut_jump (
    .clk(clk), .rst_n(rst_n), .wr(bus0), .sample_tick(sample_tick),
    .g(g0), .pending(pending0), .busy(busy0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic write(input logic [2:0] band, input logic [15:0] gain);
    bus.wr_valid = 1'b1; bus.wr_band = band; bus.wr_gain = gain;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_g;
    rst_n = 1'b0; sample_tick = 1'b0;
    bus.wr_valid = 1'b0;  bus.wr_band = '0;  bus.wr_gain = '0;  bus.commit = 1'b0;
    bus0.wr_valid = 1'b0; bus0.wr_band = '0; bus0.wr_gain = '0; bus0.commit = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 8; k++) chk($sformatf("reset_g%0d", k), g[k], 16'h4000);
    chk("reset_wr_ready", bus.wr_ready, 1'b1);
    chk("reset_pending", pending, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_jump_g1", g0[1], 16'h4000);
    rst_n = 1'b1;
    cyc();

    // commit with nothing pending stays idle
    do_commit();
    chk("idle_commit_busy", busy, 1'b0);
    chk("idle_commit_pending", pending, 1'b0);

    // upward ramp on band 2
    write(3'd2, 16'h4400);
    chk("up_pending", pending, 1'b1);
    chk("up_wr_ready_load", bus.wr_ready, 1'b1);
    do_commit();
    chk("up_armed_busy", busy, 1'b1);
    chk("up_armed_ready", bus.wr_ready, 1'b0);
    chk("up_armed_g2", g[2], 16'h4000);
    for (int i = 0; i < 4; i++) begin
      exp_g = 16'h4100 + 16'(i) * 16'h0100;
      tick();
      chk($sformatf("up_g2_t%0d", i), g[2], exp_g);
      chk($sformatf("up_busy_t%0d", i), busy, (i < 3) ? 1'b1 : 1'b0);
      cyc();
      chk($sformatf("up_hold_g2_t%0d", i), g[2], exp_g);
    end
    chk("up_other_g3", g[3], 16'h4000);
    tick();
    chk("idle_tick_g2", g[2], 16'h4400);

    // downward ramp with a sub-STEP remainder
    write(3'd5, 16'h3E80);
    do_commit();
    tick();
    chk("down_g5_t0", g[5], 16'h3F00);
    chk("down_busy_t0", busy, 1'b1);
    tick();
    chk("down_g5_t1", g[5], 16'h3E80);
    chk("down_busy_t1", busy, 1'b0);

    // write coincident with commit is included in the targets
    write(3'd6, 16'h4100);
    bus.wr_valid = 1'b1; bus.wr_band = 3'd7; bus.wr_gain = 16'h4200; bus.commit = 1'b1;
    cyc();
    bus.wr_valid = 1'b0; bus.commit = 1'b0;
    chk("sim_busy", busy, 1'b1);
    tick();
    chk("sim_g6_t0", g[6], 16'h4100);
    chk("sim_g7_t0", g[7], 16'h4100);
    chk("sim_busy_t0", busy, 1'b1);
    tick();
    chk("sim_g7_t1", g[7], 16'h4200);
    chk("sim_busy_t1", busy, 1'b0);

    // full-scale: 4000 -> 0000 in 64 ticks, then 0000 -> FFFF in 256 ticks
    write(3'd3, 16'h0000);
    do_commit();
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk("fs_down_ticks", n, 64);
    chk("fs_down_g3", g[3], 16'h0000);
    write(3'd3, 16'hFFFF);
    do_commit();
    n = 0;
    while (busy && n < 400) begin
      tick(); n++;
      if (n == 255) chk("fs_up_g3_t255", g[3], 16'hFF00);
    end
    chk("fs_up_ticks", n, 256);
    chk("fs_up_g3", g[3], 16'hFFFF);

    // backpressure during ramp, then reset mid-ramp
    write(3'd4, 16'h4300);
    do_commit();
    tick();
    chk("bp_g4_t0", g[4], 16'h4100);
    bus.wr_valid = 1'b1; bus.wr_band = 3'd0; bus.wr_gain = 16'h1000;
    cyc();
    chk("bp_wr_ready", bus.wr_ready, 1'b0);
    chk("bp_pending", pending, 1'b0);
    tick();
    chk("bp_g4_t1", g[4], 16'h4200);
    tick();
    chk("bp_g4_t2", g[4], 16'h4300);
    chk("bp_idle_ready", bus.wr_ready, 1'b1);
    chk("bp_idle_pending", pending, 1'b0);
    cyc();
    bus.wr_valid = 1'b0;
    chk("bp_accept_pending", pending, 1'b1);
    do_commit();
    tick();
    chk("bp_g0_t0", g[0], 16'h3F00);
    chk("bp_ramp_busy", busy, 1'b1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_g0", g[0], 16'h4000);
    chk("mid_rst_g3", g[3], 16'h4000);
    chk("mid_rst_g4", g[4], 16'h4000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", bus.wr_ready, 1'b1);
    cyc();

    // RAMP_EN=0 jumps straight to target on the first tick
    bus0.wr_valid = 1'b1; bus0.wr_band = 3'd1; bus0.wr_gain = 16'hFFFF;
    cyc();
    bus0.wr_valid = 1'b0; bus0.commit = 1'b1;
    cyc();
    bus0.commit = 1'b0;
    chk("jump_busy_armed", busy0, 1'b1);
    tick();
    chk("jump_g1", g0[1], 16'hFFFF);
    chk("jump_g0", g0[0], 16'h4000);
    chk("jump_busy", busy0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
